// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: owns the binary/Gray read pointer,
// synchronises the write pointer into r_clk and derives empty, fill level and underflow.
module async_fifo_rd_ctrl #(
    parameter int ADDR_WIDTH          = 4,
    parameter int SYNC_STAGES         = 2,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  r_req,
    input  logic [ADDR_WIDTH:0]   w_ptr_gray,
    output logic                  r_en,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  r_valid,
    output logic [ADDR_WIDTH:0]   r_ptr_gray,
    output logic                  r_empty,
    output logic                  r_almost_empty,
    output logic [ADDR_WIDTH:0]   r_count,
    output logic                  r_underflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_THRESH = PW'(ALMOST_EMPTY_THRESH);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [PW-1:0] wsync_q [SYNC_STAGES];
    logic [PW-1:0] wq_gray;

    logic [PW-1:0] rbin_q,      rbin_d;
    logic [PW-1:0] rgray_q,     rgray_d;
    logic          empty_q,     empty_d;
    logic          aempty_q,    aempty_d;
    logic [PW-1:0] count_q,     count_d;
    logic          valid_q,     valid_d;
    logic          underflow_q, underflow_d;
    logic          r_fire;

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                wsync_q[i] <= '0;
            end
        end else begin
            wsync_q[0] <= w_ptr_gray;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                wsync_q[i] <= wsync_q[i-1];
            end
        end
    end

    assign wq_gray = wsync_q[SYNC_STAGES-1];

    // Status is computed from the post-read pointer so an accept and a new
    // synchronised write pointer are both reflected on the same edge.
    always_comb begin
        r_fire      = r_req & ~empty_q & ~r_rst;
        rbin_d      = rbin_q + {{ADDR_WIDTH{1'b0}}, r_fire};
        rgray_d     = bin2gray(rbin_d);
        empty_d     = (rgray_d == wq_gray);
        count_d     = gray2bin(wq_gray) - rbin_d;
        aempty_d    = (count_d <= AE_THRESH);
        valid_d     = r_fire;
        underflow_d = r_req & empty_q & ~r_rst;
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            count_q     <= '0;
            valid_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rbin_q      <= rbin_d;
            rgray_q     <= rgray_d;
            empty_q     <= empty_d;
            aempty_q    <= aempty_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            underflow_q <= underflow_d;
        end
    end

    assign r_en           = r_fire;
    assign r_addr         = rbin_q[ADDR_WIDTH-1:0];
    assign r_valid        = valid_q;
    assign r_ptr_gray     = rgray_q;
    assign r_empty        = empty_q;
    assign r_almost_empty = aempty_q;
    assign r_count        = count_q;
    assign r_underflow    = underflow_q;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Bench for async_fifo_rd_ctrl: directed status/latency cases plus a data scoreboard
// fed through a bench-side memory model with a 1-cycle registered read.
module tb_async_fifo_rd_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          r_rst;
    logic          r_req;
    logic [AW:0]   w_ptr_gray;
    logic          r_en;
    logic [AW-1:0] r_addr;
    logic          r_valid;
    logic [AW:0]   r_ptr_gray;
    logic          r_empty;
    logic          r_almost_empty;
    logic [AW:0]   r_count;
    logic          r_underflow;

    async_fifo_rd_ctrl #(
        .ADDR_WIDTH         (AW),
        .SYNC_STAGES        (2),
        .ALMOST_EMPTY_THRESH(2)
    ) dut (
        .r_clk         (clk),
        .r_rst         (r_rst),
        .r_req         (r_req),
        .w_ptr_gray    (w_ptr_gray),
        .r_en          (r_en),
        .r_addr        (r_addr),
        .r_valid       (r_valid),
        .r_ptr_gray    (r_ptr_gray),
        .r_empty       (r_empty),
        .r_almost_empty(r_almost_empty),
        .r_count       (r_count),
        .r_underflow   (r_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata;
    logic [7:0] sb [$];
    logic [AW:0] wbin;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input int n);
        logic [7:0] d;
        for (int k = 0; k < n; k++) begin
            d = 8'($urandom);
            mem[wbin[AW-1:0]] = d;
            sb.push_back(d);
            wbin = wbin + 1'b1;
        end
        w_ptr_gray = gray(wbin);
    endtask

    always @(posedge clk) begin
        if (r_en) rdata <= mem[r_addr];
    end

    always @(negedge clk) begin
        if (r_valid === 1'b1) begin
            if (sb.size() == 0) chk("sb_underrun", sb.size(), 1);
            else chk("sb_data", rdata, sb.pop_front());
        end
    end

    logic [AW:0] exp_g [3];
    int budget;

    initial begin
        exp_g[0] = 5'b00001; exp_g[1] = 5'b00011; exp_g[2] = 5'b00010;
        wbin       = '0;
        r_rst      = 1'b1;
        r_req      = 1'b1;
        w_ptr_gray = '0;

        // Reset held with a pending request
        for (int i = 0; i < 2; i++) begin
            #1 chk("rst_ren", r_en, 0);
            @(posedge clk);
        end
        #1;
        chk("rst_empty",  r_empty, 1);
        chk("rst_aempty", r_almost_empty, 1);
        chk("rst_count",  r_count, 0);
        chk("rst_ptr",    r_ptr_gray, 0);
        chk("rst_valid",  r_valid, 0);
        chk("rst_uflow",  r_underflow, 0);
        r_rst = 1'b0;
        r_req = 1'b0;

        // Write pointer crossing latency
        write_words(3);
        tick(); chk("sync_e1", r_empty, 1);
        tick(); chk("sync_e2", r_empty, 1);
        tick(); chk("sync_e3", r_empty, 0);
        chk("sync_count",  r_count, 3);
        chk("sync_aempty", r_almost_empty, 0);

        // Three-read burst
        r_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("burst_ren",  r_en, 1);
            chk("burst_addr", r_addr, i);
            tick();
            chk("burst_count",  r_count, 2 - i);
            chk("burst_aempty", r_almost_empty, 1);
            chk("burst_ptr",    r_ptr_gray, exp_g[i]);
            chk("burst_valid",  r_valid, 1);
        end
        chk("burst_empty", r_empty, 1);

        // Underflow on empty
        #1 chk("uf_ren", r_en, 0);
        tick();
        chk("uf_pulse", r_underflow, 1);
        chk("uf_ptr",   r_ptr_gray, 5'b00010);
        chk("uf_count", r_count, 0);
        chk("uf_valid", r_valid, 0);
        r_req = 1'b0;
        tick();
        chk("uf_clear", r_underflow, 0);

        // Reset in the middle of a burst
        write_words(3);
        tick(); tick(); tick();
        chk("mid_count", r_count, 3);
        r_req = 1'b1;
        #1 chk("mid_ren", r_en, 1);
        tick();
        r_rst = 1'b1;
        w_ptr_gray = '0;
        wbin = '0;
        #1 chk("mid_rst_ren", r_en, 0);
        tick();
        sb.delete();
        chk("mid_valid", r_valid, 0);
        chk("mid_ptr",   r_ptr_gray, 0);
        chk("mid_empty", r_empty, 1);
        chk("mid_count0", r_count, 0);
        r_rst = 1'b0;
        r_req = 1'b0;

        // Full wrap: 16 entries, count distinguishes full from empty by MSB
        write_words(DEPTH);
        tick(); tick(); tick();
        chk("full_count", r_count, DEPTH);
        chk("full_empty", r_empty, 0);
        chk("full_aempty", r_almost_empty, 0);
        r_req = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("wrap_ren",  r_en, 1);
            chk("wrap_addr", r_addr, i);
            tick();
        end
        r_req = 1'b0;
        chk("wrap_ptr",   r_ptr_gray, 5'b11000);
        chk("wrap_count", r_count, 0);
        chk("wrap_empty", r_empty, 1);
        write_words(1);
        chk("wrap_wgray", w_ptr_gray, 5'b11001);
        tick(); tick(); tick();
        chk("wrap2_empty", r_empty, 0);
        chk("wrap2_count", r_count, 1);
        r_req = 1'b1;
        #1;
        chk("wrap2_ren",  r_en, 1);
        chk("wrap2_addr", r_addr, 0);
        tick();
        r_req = 1'b0;

        // Random traffic against the data scoreboard
        for (int c = 0; c < 1500; c++) begin
            r_req = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0 && sb.size() < DEPTH) write_words(1);
            tick();
            chk("rnd_cnt_max", (r_count <= DEPTH), 1);
            chk("rnd_empty_cnt", r_empty, (r_count == 0));
            chk("rnd_aempty", r_almost_empty, (r_count <= 2));
            chk("rnd_uf_vs_valid", (r_underflow & r_valid), 0);
        end

        // Drain everything still outstanding
        r_req  = 1'b1;
        budget = 0;
        while (sb.size() != 0 && budget < 200) begin
            tick();
            budget++;
        end
        chk("drain_done", sb.size(), 0);
        r_req = 1'b0;
        tick(); tick();
        chk("drain_empty", r_empty, 1);
        chk("drain_count", r_count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
